// File: rtl/cla_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage.
// Define CLA_PIPE_FLAGS_EN to add registered cout/ovf/zero outputs aligned with sum.
module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CLA_PIPE_FLAGS_EN
    output logic             cout,
    output logic             ovf,
    output logic             zero,
`endif
    output logic [WIDTH-1:0] sum
);

    localparam int C  = WIDTH / STAGES;
    localparam int NG = C / 8;

    function automatic logic [C:0] cla_slice(
        input logic [C-1:0] x,
        input logic [C-1:0] y,
        input logic         c0
    );
        logic [C-1:0]  g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          t;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                gg[j] = g[j*8+i] | (p[j*8+i] & gg[j]);
                gp[j] = gp[j] & p[j*8+i];
            end
        end
        // group carries in flat sum-of-products form: no group waits on another
        for (int j = 0; j <= NG; j++) begin
            t = c0;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < 8; i++) begin
                t = gc[j];
                for (int m = 0; m < i; m++) t = t & p[j*8+m];
                c[j*8+i] = t;
                for (int l = 0; l < i; l++) begin
                    t = g[j*8+l];
                    for (int m = l + 1; m < i; m++) t = t & p[j*8+m];
                    c[j*8+i] = c[j*8+i] | t;
                end
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    logic adv;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int UW = WIDTH - k * C;

        logic [UW-1:0]        xa, xb;
        logic                 xc, xv;
        logic [C:0]           r;
        logic [(k+1)*C-1:0]   ns;

        if (k == 0) begin : g_src
            assign xa = a;
            assign xb = sub ? ~b : b;
            assign xc = sub | cin;
            assign xv = in_valid;
            assign ns = r[C-1:0];
        end else begin : g_src
            assign xa = g_st[k-1].g_reg.ra;
            assign xb = g_st[k-1].g_reg.rb;
            assign xc = g_st[k-1].g_reg.rc;
            assign xv = g_st[k-1].g_reg.rv;
            assign ns = {r[C-1:0], g_st[k-1].g_reg.rs};
        end

        assign r = cla_slice(xa[C-1:0], xb[C-1:0], xc);

        if (k < STAGES - 1) begin : g_reg
            // only the not-yet-added upper slices travel on
            logic [UW-C-1:0]    ra, rb;
            logic [(k+1)*C-1:0] rs;
            logic               rc, rv;

            always_ff @(posedge clk) begin
                if (rst) rv <= 1'b0;
                else if (adv) rv <= xv;
                if (adv) begin
                    ra <= xa[UW-1:C];
                    rb <= xb[UW-1:C];
                    rc <= r[C];
                    rs <= ns;
                end
            end
        end else begin : g_out
`ifndef CLA_PIPE_FLAGS_EN
            logic unused_c;
            assign unused_c = r[C];
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
`ifdef CLA_PIPE_FLAGS_EN
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
`endif
                end else if (adv) begin
                    out_valid <= xv;
                    if (xv) begin
                        sum  <= ns;
`ifdef CLA_PIPE_FLAGS_EN
                        cout <= r[C];
                        ovf  <= (xa[C-1] == xb[C-1]) && (r[C-1] != xa[C-1]);
                        zero <= (ns == '0);
`endif
                    end
                end
            end
        end
    end

endmodule
